// File: rtl/uart_pkg.sv
// Shared types and widths for the UART transmitter arbiter.
package uart_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned GRANT_W = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_ACC  = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin encoder: first set request strictly after ptr, wrapping.
module rr_picker
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [GRANT_W-1:0] ptr_i,
  output logic               valid_c_o,
  output logic [GRANT_W-1:0] idx_c_o
);

  localparam int unsigned         SLOTS = 1 << GRANT_W;
  localparam logic [GRANT_W:0]    N_W   = (GRANT_W+1)'(NUM_REQ);

  logic [SLOTS-1:0] req_w;
  logic [GRANT_W:0] cand;

  assign req_w = SLOTS'(req_i);

  // ptr + k never exceeds 2*NUM_REQ-1, so one conditional subtract wraps it
  always_comb begin
    valid_c_o = 1'b0;
    idx_c_o   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (GRANT_W+1)'(ptr_i) + (GRANT_W+1)'(k);
      if (cand >= N_W) cand = cand - N_W;
      if (!valid_c_o && req_w[cand[GRANT_W-1:0]]) begin
        valid_c_o = 1'b1;
        idx_c_o   = cand[GRANT_W-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART sender between NUM_REQ byte producers with round-robin grant,
// accept timeout/retry and per-requester ack.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ACCEPT_TO = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      done,
  output logic [GRANT_W-1:0]        grant_id,
  output logic                      busy,
  output logic                      TX_EN,
  output logic [BYTE_W-1:0]         TX_DATA,
  input  logic                      TX_STATUS
);

  localparam int unsigned         TMR_W    = (ACCEPT_TO > 1) ? $clog2(ACCEPT_TO) : 1;
  localparam logic [TMR_W-1:0]    TMR_LAST = TMR_W'(ACCEPT_TO - 1);
  localparam logic [GRANT_W-1:0]  PTR_RST  = GRANT_W'(NUM_REQ - 1);

  arb_state_e          state_q, state_d;
  logic [GRANT_W-1:0]  ptr_q, ptr_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [BYTE_W-1:0]   data_q, data_d;
  logic [GRANT_W-1:0]  grant_q, grant_d;
  logic                busy_q, busy_d;
  logic                tx_en_q, tx_en_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                done_q, done_d;

  logic                pick_valid;
  logic [GRANT_W-1:0]  pick_idx;
  logic [BYTE_W-1:0]   pick_byte;
  logic [NUM_REQ-1:0]  grant_onehot;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .valid_c_o (pick_valid),
    .idx_c_o   (pick_idx)
  );

  // Winner's byte and the one-hot ack vector for the held grant
  always_comb begin
    pick_byte    = '0;
    grant_onehot = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == GRANT_W'(i)) pick_byte = req_data[BYTE_W*i +: BYTE_W];
      grant_onehot[i] = (grant_q == GRANT_W'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    timer_d = timer_q;
    data_d  = data_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    tx_en_d = 1'b0;
    ack_d   = '0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (TX_STATUS && pick_valid) begin
          data_d  = pick_byte;
          grant_d = pick_idx;
          busy_d  = 1'b1;
          tx_en_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT_ACC;
      end
      WAIT_ACC: begin
        if (!TX_STATUS) begin
          ack_d   = grant_onehot;
          state_d = WAIT_DONE;
        end else if (timer_q == TMR_LAST) begin
          // sender never took the pulse: re-issue the same byte
          tx_en_d = 1'b1;
          state_d = ISSUE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (TX_STATUS) begin
          done_d  = 1'b1;
          ptr_d   = grant_q;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= PTR_RST;
      timer_q <= '0;
      data_q  <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      tx_en_q <= 1'b0;
      ack_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      timer_q <= timer_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      tx_en_q <= tx_en_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
    end
  end

  assign ack      = ack_q;
  assign done     = done_q;
  assign grant_id = grant_q;
  assign busy     = busy_q;
  assign TX_EN    = tx_en_q;
  assign TX_DATA  = data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter against a transaction-level reference model and sender model.
module tb_uart_tx_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned TO = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   ack;
  logic           done;
  logic [2:0]     grant_id;
  logic           busy;
  logic           TX_EN;
  logic [7:0]     TX_DATA;
  logic           TX_STATUS;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .ACCEPT_TO(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .done      (done),
    .grant_id  (grant_id),
    .busy      (busy),
    .TX_EN     (TX_EN),
    .TX_DATA   (TX_DATA),
    .TX_STATUS (TX_STATUS)
  );

  int checks = 0;
  int errors = 0;

  // reference model: arbiter idle flag, last served, current grant/byte, accept phase
  bit       m_idle, m_acc;
  int       m_last, m_grant, m_age;
  logic [7:0] m_byte;
  // sender model
  bit       snd_start;
  int       snd_left, deaf, frame_fix;
  // requester model
  bit       rand_on, hold0;
  logic [N-1:0] wait_ack;
  // observation
  int       cyc, en_seen, done_seen;
  int       obs_order[$];
  int       en_times[$];
  bit       prev_busy;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic int winner(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= int'(N); k++) begin
      int j;
      j = (last + k) % int'(N);
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic step();
    bit           p_reset, p_status, exp_en, exp_done, start_now;
    logic [N-1:0] p_req, exp_ack, one;
    logic [8*N-1:0] p_data;
    p_reset = reset; p_status = TX_STATUS; p_req = req; p_data = req_data;
    one = 1;
    @(posedge clk);
    #1;
    cyc++;
    exp_en = 1'b0; exp_done = 1'b0; exp_ack = '0;
    if (p_reset) begin
      m_idle = 1; m_acc = 0; m_last = N - 1; m_grant = 0; m_byte = 8'h00; wait_ack = '0;
    end else if (m_idle) begin
      if (p_status && p_req != '0) begin
        m_grant = winner(p_req, m_last);
        m_byte  = p_data[8*m_grant +: 8];
        m_idle = 0; m_acc = 1; m_age = 0; exp_en = 1'b1;
      end
    end else if (m_acc) begin
      m_age++;
      if (m_age >= 2 && !p_status) begin
        exp_ack = one << m_grant;
        m_acc = 0;
      end else if (m_age == int'(TO) + 1) begin
        exp_en = 1'b1;
        m_age = 0;
      end
    end else if (p_status) begin
      exp_done = 1'b1; m_idle = 1; m_last = m_grant;
    end

    check_eq("tx_en", 32'(TX_EN), 32'(exp_en));
    check_eq("ack", 32'(ack), 32'(exp_ack));
    check_eq("done", 32'(done), 32'(exp_done));
    check_eq("busy", 32'(busy), 32'(!m_idle));
    check_eq("grant_id", 32'(grant_id), 32'(m_grant));
    check_eq("tx_data", 32'(TX_DATA), 32'(m_byte));

    if (TX_EN) begin
      en_seen++;
      en_times.push_back(cyc);
      if (!prev_busy) obs_order.push_back(int'(grant_id));
    end
    if (done) done_seen++;
    prev_busy = busy;

    // sender: samples TX_EN on the next edge, then stays busy for a frame
    start_now = TX_EN && TX_STATUS && !snd_start && snd_left == 0;
    if (start_now && deaf > 0) begin deaf--; start_now = 0; end
    if (snd_left > 0) begin
      snd_left--;
      if (snd_left == 0) TX_STATUS = 1'b1;
    end
    if (snd_start) begin
      snd_start = 0; TX_STATUS = 1'b0;
      snd_left = (frame_fix != 0) ? frame_fix : int'($urandom_range(6, 1));
    end
    if (start_now) snd_start = 1;
    if (rand_on && deaf == 0 && $urandom_range(31, 0) == 0) deaf = 1;

    // requesters: drop on ack, optionally drop early after grant, raise new bytes
    for (int i = 0; i < int'(N); i++) begin
      if (ack[i]) begin
        wait_ack[i] = 1'b0;
        if (!(hold0 && i == 0)) req[i] = 1'b0;
      end
    end
    if (rand_on && m_acc && req[m_grant] && $urandom_range(7, 0) == 0) begin
      req[m_grant] = 1'b0; wait_ack[m_grant] = 1'b1;
    end
    if (rand_on) begin
      for (int i = 0; i < int'(N); i++) begin
        if (!req[i] && !wait_ack[i] && $urandom_range(3, 0) == 0) begin
          req[i] = 1'b1;
          req_data[8*i +: 8] = 8'($urandom);
        end
      end
    end
  endtask

  task automatic run_dones(input int n, input string tag);
    int target, b;
    target = done_seen + n; b = 0;
    while (done_seen < target && b < 2000) begin step(); b++; end
    check_eq({tag, "_done_reached"}, 32'(done_seen >= target), 32'd1);
  endtask

  initial begin
    int b, base;
    reset = 1'b1; req = '0; req_data = '0; TX_STATUS = 1'b0;
    m_idle = 1; m_acc = 0; m_last = N - 1; m_grant = 0; m_age = 0; m_byte = 8'h00;
    snd_start = 0; snd_left = 0; deaf = 0; frame_fix = 0;
    rand_on = 0; hold0 = 0; wait_ack = '0;
    cyc = 0; en_seen = 0; done_seen = 0; prev_busy = 0;

    step(); step();
    reset = 1'b0;

    // sender busy out of reset: request must wait for TX_STATUS
    req = 4'b0001; req_data[7:0] = 8'h3C;
    repeat (6) step();
    check_eq("busy_sender_no_en", 32'(en_seen), 32'd0);
    TX_STATUS = 1'b1;
    run_dones(1, "first");

    // single request with latency checks
    req_data[23:16] = 8'hA5; req = 4'b0100;
    step();
    check_eq("single_en", 32'(TX_EN), 32'd1);
    check_eq("single_data", 32'(TX_DATA), 32'hA5);
    step();
    check_eq("single_en_one_cycle", 32'(TX_EN), 32'd0);
    step();
    check_eq("single_ack", 32'(ack), 32'b0100);
    run_dones(1, "single");

    // round robin from fresh pointer
    reset = 1'b1; step(); reset = 1'b0;
    obs_order.delete();
    req_data = {$urandom}; req = 4'b1111;
    run_dones(4, "rr");
    check_eq("rr_count", 32'(obs_order.size()), 32'd4);
    for (int i = 0; i < 4 && i < obs_order.size(); i++)
      check_eq("rr_order", 32'(obs_order[i]), 32'(i));

    // requester 0 keeps req up through ack: 0,1,0
    obs_order.delete();
    hold0 = 1; req[0] = 1'b1; req[1] = 1'b1;
    run_dones(2, "rereq_a");
    hold0 = 0;
    run_dones(1, "rereq_b");
    check_eq("rereq_count", 32'(obs_order.size()), 32'd3);
    if (obs_order.size() == 3) begin
      check_eq("rereq_0", 32'(obs_order[0]), 32'd0);
      check_eq("rereq_1", 32'(obs_order[1]), 32'd1);
      check_eq("rereq_2", 32'(obs_order[2]), 32'd0);
    end

    // sender ignores two pulses: retries every TO+1 cycles
    en_times.delete();
    deaf = 2; req[1] = 1'b1; req_data[15:8] = 8'h5A;
    run_dones(1, "timeout");
    check_eq("timeout_pulses", 32'(en_times.size()), 32'd3);
    if (en_times.size() == 3) begin
      check_eq("timeout_gap0", 32'(en_times[1] - en_times[0]), 32'(TO + 1));
      check_eq("timeout_gap1", 32'(en_times[2] - en_times[1]), 32'(TO + 1));
    end

    // reset while waiting for frame completion
    frame_fix = 10; req[3] = 1'b1; req_data[31:24] = 8'hC3;
    b = 0;
    while (ack == '0 && b < 40) begin step(); b++; end
    check_eq("abort_ack_seen", 32'(ack), 32'b1000);
    step();
    check_eq("abort_in_wait_done", 32'(busy), 32'd1);
    reset = 1'b1; step(); reset = 1'b0;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_en", 32'(TX_EN), 32'd0);
    check_eq("abort_ack", 32'(ack), 32'd0);
    base = done_seen;
    repeat (20) step();
    check_eq("abort_no_done", 32'(done_seen - base), 32'd0);
    frame_fix = 0;

    // randomized traffic, then drain
    rand_on = 1;
    repeat (3000) step();
    rand_on = 0;
    b = 0;
    while (!(m_idle && req == '0) && b < 1000) begin step(); b++; end
    check_eq("drain_idle", 32'(m_idle && req == '0), 32'd1);
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
